// File: rtl/stream_demux_if.sv
// ----------------------------------------------------------------------------
// stream_demux_if
// Bundles the upstream valid/ready stream, the N downstream lanes and the
// routing/status side signals of stream_demux.
//   up_valid/up_ready/up_data/up_sel : single upstream stream plus lane select
//   mode_rr                          : 1 = round-robin routing, 0 = explicit
//   down_valid/down_ready/down_data  : N lanes, lane i at [i*WIDTH +: WIDTH]
//   drop                             : pulse, a beat with an illegal select was discarded
//   rr_ptr                           : current round-robin pointer
// master = producer/consumer environment side, slave = the demux itself.
// ----------------------------------------------------------------------------
interface stream_demux_if #(
    parameter int WIDTH = 8,
    parameter int N     = 4
);
    localparam int SEL_W = $clog2(N);

    logic               up_valid;
    logic               up_ready;
    logic [WIDTH-1:0]   up_data;
    logic [SEL_W-1:0]   up_sel;
    logic               mode_rr;
    logic [N-1:0]       down_valid;
    logic [N-1:0]       down_ready;
    logic [N*WIDTH-1:0] down_data;
    logic               drop;
    logic [SEL_W-1:0]   rr_ptr;

    modport master (
        output up_valid, up_data, up_sel, mode_rr, down_ready,
        input  up_ready, down_valid, down_data, drop, rr_ptr
    );

    modport slave (
        input  up_valid, up_data, up_sel, mode_rr, down_ready,
        output up_ready, down_valid, down_data, drop, rr_ptr
    );
endinterface

// File: rtl/stream_demux.sv
// ----------------------------------------------------------------------------
// stream_demux
// Registered 1-to-N valid/ready demultiplexer. Each beat is steered to lane
// T = mode_rr ? rr_ptr : up_sel and parked in that lane's one-entry slot, so
// a stalled lane never disturbs the others. A full slot whose consumer is
// ready this cycle counts as free (drain and reload on the same edge).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : stream_demux_if.slave (upstream stream, N lanes, drop, rr_ptr)
// ----------------------------------------------------------------------------
module stream_demux #(
    parameter int WIDTH = 8,
    parameter int N     = 4
) (
    input  logic           clk,
    input  logic           rst,
    stream_demux_if.slave  bus
);
    localparam int SEL_W = $clog2(N);
    // One extra bit so the legality test also works when N is a power of two.
    localparam logic [SEL_W:0]   N_EXT = (SEL_W + 1)'(N);
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(N - 1);

    logic [N-1:0]       vld_p1;
    logic [N*WIDTH-1:0] data_p1;
    logic               drop_p1;
    logic [SEL_W-1:0]   rr_ptr_p1;

    logic [SEL_W-1:0]   tgt;
    logic               tgt_ok;
    logic               tgt_free;
    logic               up_ready;
    logic               accept;
    logic [N-1:0]       load;

    // ---- stage p0: routing decision (combinational, no up_valid -> up_ready path)
    always_comb begin
        tgt      = bus.mode_rr ? rr_ptr_p1 : bus.up_sel;
        tgt_ok   = {1'b0, tgt} < N_EXT;
        tgt_free = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (tgt == SEL_W'(i)) begin
                tgt_free = ~vld_p1[i] | bus.down_ready[i];
            end
        end
        // Illegal explicit select is accepted and discarded.
        up_ready = tgt_ok ? tgt_free : ~bus.mode_rr;
        accept   = bus.up_valid & up_ready;
        load     = '0;
        for (int i = 0; i < N; i++) begin
            load[i] = accept & tgt_ok & (tgt == SEL_W'(i));
        end
    end

    // ---- stage p1: per-lane holding slots, drop pulse, round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1    <= '0;
            data_p1   <= '0;
            drop_p1   <= 1'b0;
            rr_ptr_p1 <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (load[i]) begin
                    vld_p1[i]                  <= 1'b1;
                    data_p1[i*WIDTH +: WIDTH]  <= bus.up_data;
                end else if (bus.down_ready[i]) begin
                    vld_p1[i]                  <= 1'b0;
                end
            end
            drop_p1 <= accept & ~tgt_ok;
            if (accept && bus.mode_rr) begin
                rr_ptr_p1 <= (rr_ptr_p1 == LAST) ? '0 : rr_ptr_p1 + SEL_W'(1);
            end
        end
    end

    assign bus.up_ready   = up_ready;
    assign bus.down_valid = vld_p1;
    assign bus.down_data  = data_p1;
    assign bus.drop       = drop_p1;
    assign bus.rr_ptr     = rr_ptr_p1;
endmodule

// File: tb/tb_stream_demux.sv
// ----------------------------------------------------------------------------
// tb_stream_demux
// Drives an N=4 and an N=3 stream_demux (one active at a time) and compares
// every cycle against a lane-slot model kept in the bench, plus directed
// scenarios for explicit routing, round-robin wrap, backpressure, lane
// independence, illegal select and pointer stall.
// ----------------------------------------------------------------------------
module tb_stream_demux;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stream_demux_if #(.WIDTH(8), .N(4)) bus4 ();
    stream_demux_if #(.WIDTH(8), .N(3)) bus3 ();

    stream_demux #(.WIDTH(8), .N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));
    stream_demux #(.WIDTH(8), .N(3)) u_dut3 (.clk(clk), .rst(rst), .bus(bus3.slave));

    // Shared stimulus; only the active instance sees up_valid.
    int         cur_n = 4;
    logic       up_valid = 1'b0;
    logic [7:0] up_data  = '0;
    logic [1:0] up_sel   = '0;
    logic       mode_rr  = 1'b0;
    logic [3:0] dr       = '0;

    assign bus4.up_valid   = up_valid && (cur_n == 4);
    assign bus4.up_data    = up_data;
    assign bus4.up_sel     = up_sel;
    assign bus4.mode_rr    = mode_rr;
    assign bus4.down_ready = dr;
    assign bus3.up_valid   = up_valid && (cur_n == 3);
    assign bus3.up_data    = up_data;
    assign bus3.up_sel     = up_sel;
    assign bus3.mode_rr    = mode_rr;
    assign bus3.down_ready = dr[2:0];

    logic        obs_ready;
    logic [3:0]  obs_dv;
    logic [31:0] obs_dd;
    logic [1:0]  obs_ptr;
    logic        obs_drop;

    always_comb begin
        if (cur_n == 4) begin
            obs_ready = bus4.up_ready;
            obs_dv    = bus4.down_valid;
            obs_dd    = bus4.down_data;
            obs_ptr   = bus4.rr_ptr;
            obs_drop  = bus4.drop;
        end else begin
            obs_ready = bus3.up_ready;
            obs_dv    = {1'b0, bus3.down_valid};
            obs_dd    = {8'h00, bus3.down_data};
            obs_ptr   = bus3.rr_ptr;
            obs_drop  = bus3.drop;
        end
    end

    // Reference model: each lane holds at most one beat.
    bit         mv[4];
    logic [7:0] md[4];
    int         mptr;
    bit         mdrop;
    bit         last_acc;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            mv[i] = 0;
            md[i] = '0;
        end
        mptr  = 0;
        mdrop = 0;
    endtask

    // One clock: check outputs at the falling edge, advance the model, and
    // return 1 ns after the next rising edge.
    task automatic step();
        int t;
        bit rdy;
        bit acc;
        @(negedge clk);
        t   = mode_rr ? mptr : int'(up_sel);
        rdy = (t < cur_n) ? (!mv[t] || dr[t]) : !mode_rr;
        check("up_ready", {31'b0, obs_ready}, {31'b0, rdy});
        for (int i = 0; i < cur_n; i++) begin
            check("down_valid", {31'b0, obs_dv[i]}, {31'b0, mv[i]});
            if (mv[i]) check("down_data", {24'b0, obs_dd[i*8 +: 8]}, {24'b0, md[i]});
        end
        check("rr_ptr", {30'b0, obs_ptr}, mptr);
        check("drop", {31'b0, obs_drop}, {31'b0, mdrop});
        acc = up_valid && rdy;
        for (int i = 0; i < cur_n; i++) begin
            if (mv[i] && dr[i]) mv[i] = 0;
        end
        mdrop = acc && (t >= cur_n);
        if (acc && t < cur_n) begin
            mv[t] = 1;
            md[t] = up_data;
        end
        if (acc && mode_rr) mptr = (mptr + 1) % cur_n;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        up_valid = 1'b0;
        dr       = '0;
        cur_n    = n;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        check("rst_dv", {28'b0, obs_dv}, 32'h0);
        check("rst_dd", obs_dd, 32'h0);
        check("rst_ptr", {30'b0, obs_ptr}, 32'h0);
        check("rst_drop", {31'b0, obs_drop}, 32'h0);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        bit pending;
        model_reset();

        // Explicit route and reset mid-hold.
        do_reset(4);
        mode_rr = 1'b0;
        up_valid = 1'b1; up_data = 8'hA1; up_sel = 2'd2;
        step();
        up_valid = 1'b0;
        check("route_dv", {28'b0, obs_dv}, 32'h4);
        check("route_data", {24'b0, obs_dd[23:16]}, 32'hA1);
        check("route_others", {obs_dd[31:24], obs_dd[15:0]}, 32'h0);
        step();
        #2 rst = 1'b1;
        #1 check("async_rst_dv", {28'b0, obs_dv}, 32'h0);
        check("async_rst_dd", obs_dd, 32'h0);
        do_reset(4);

        // Round-robin wrap, all consumers ready.
        mode_rr = 1'b1; dr = 4'hF;
        for (int k = 0; k < 6; k++) begin
            up_valid = 1'b1; up_data = 8'h10 + 8'(k);
            step();
            check("rr_lane_valid", {31'b0, obs_dv[k % 4]}, 32'h1);
            check("rr_lane_data", {24'b0, obs_dd[(k % 4)*8 +: 8]}, 32'h10 + k);
        end
        up_valid = 1'b0;
        check("rr_ptr_end", {30'b0, obs_ptr}, 32'h2);
        step();

        // Backpressure on lane 1.
        mode_rr = 1'b0; dr = 4'b1101;
        up_valid = 1'b1; up_data = 8'h55; up_sel = 2'd1;
        step();
        up_data = 8'h66;
        step();
        check("bp_ready", {31'b0, obs_ready}, 32'h0);
        check("bp_hold", {24'b0, obs_dd[15:8]}, 32'h55);
        step();
        check("bp_hold2", {24'b0, obs_dd[15:8]}, 32'h55);
        dr[1] = 1'b1;
        step();
        dr[1] = 1'b0; up_valid = 1'b0;
        check("bp_reload_v", {31'b0, obs_dv[1]}, 32'h1);
        check("bp_reload_d", {24'b0, obs_dd[15:8]}, 32'h66);
        dr = 4'hF;
        step();

        // Lane 0 stalled, lane 3 streams at full rate.
        dr = 4'b1110;
        up_valid = 1'b1; up_data = 8'h01; up_sel = 2'd0;
        step();
        for (int k = 0; k < 4; k++) begin
            up_data = 8'h30 + 8'(k); up_sel = 2'd3;
            step();
            check("indep_l3", {24'b0, obs_dd[31:24]}, 32'h30 + k);
            check("indep_l0", {24'b0, obs_dd[7:0]}, 32'h01);
        end
        up_valid = 1'b0; dr = 4'hF;
        step();

        // Pointer does not move while the target lane is stalled.
        do_reset(4);
        mode_rr = 1'b1; dr = 4'b1110;
        for (int k = 0; k < 5; k++) begin
            up_valid = 1'b1; up_data = 8'h90 + 8'(k);
            step();
        end
        check("stall_ptr", {30'b0, obs_ptr}, 32'h0);
        check("stall_ready", {31'b0, obs_ready}, 32'h0);
        dr[0] = 1'b1;
        step();
        up_valid = 1'b0;
        check("stall_ptr_adv", {30'b0, obs_ptr}, 32'h1);
        check("stall_l0", {24'b0, obs_dd[7:0]}, 32'h94);
        step();

        // Illegal select and round-robin on N=3.
        do_reset(3);
        mode_rr = 1'b0; dr = 4'hF;
        up_valid = 1'b1; up_data = 8'h77; up_sel = 2'd3;
        #1 check("ill_ready", {31'b0, obs_ready}, 32'h1);
        step();
        up_valid = 1'b0;
        check("ill_drop", {31'b0, obs_drop}, 32'h1);
        check("ill_dv", {28'b0, obs_dv}, 32'h0);
        step();
        check("ill_drop_end", {31'b0, obs_drop}, 32'h0);
        mode_rr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            up_valid = 1'b1; up_data = 8'h40 + 8'(k);
            step();
            check("rr3_lane", {24'b0, obs_dd[(k % 3)*8 +: 8]}, 32'h40 + k);
        end
        up_valid = 1'b0;
        step();

        // Randomized traffic on both widths.
        for (int n = 4; n >= 3; n--) begin
            do_reset(n);
            pending = 0;
            for (int c = 0; c < 2000; c++) begin
                if (!pending) begin
                    up_valid = ($urandom_range(0, 3) != 0);
                    up_data  = 8'($urandom);
                    up_sel   = 2'($urandom);
                    if ($urandom_range(0, 7) == 0) mode_rr = ~mode_rr;
                end
                dr = 4'($urandom);
                step();
                pending = up_valid && !last_acc;
            end
            up_valid = 1'b0;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
# stream_demux

Registered 1-to-N valid/ready stream demultiplexer: the routing counterpart of the team's selector mux. It steers each beat from one upstream stream to one of N downstream streams, chosen either by an explicit select or by an internal round-robin pointer. Each output has a one-entry holding register, so downstream stalls on one lane never corrupt or block data already delivered to other lanes. It sits between a single producer and N parallel consumers, e.g. lane workers or per-channel FIFOs.

## Interface
Parameters:
- WIDTH, 8, payload width in bits (≥1)
- N, 4, number of output lanes (2..16, need not be a power of two)
- SEL_W, $clog2(N), select width; derived, not overridden

Ports:
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  reset, asynchronous assert, active-high
- up_valid  in  1  upstream beat present
- up_ready  out  1  upstream beat accepted this cycle when up_valid & up_ready
- up_data  in  WIDTH  upstream payload
- up_sel  in  SEL_W  target lane in explicit mode; sampled with the beat
- mode_rr  in  1  1 = round-robin routing, up_sel ignored; 0 = explicit routing
- down_valid  out  N  per-lane beat present
- down_ready  in  N  per-lane consumer ready
- down_data  out  N*WIDTH  lane i payload at bits [i*WIDTH +: WIDTH]
- drop  out  1  one-cycle pulse: a beat with up_sel ≥ N was discarded
- rr_ptr  out  SEL_W  current round-robin pointer (observability)

## Operation
- Target lane T = mode_rr ? rr_ptr : up_sel.
- Per-lane slot: valid bit plus data register. Slot i is free when valid_i = 0, or when valid_i = 1 and down_ready[i] = 1 in the same cycle (pass-through on drain).
- up_ready = 1 when T < N and slot T is free; also 1 when mode_rr = 0 and up_sel ≥ N (illegal select: accept and discard).
- Accept (up_valid & up_ready, T < N): slot T loads up_data and sets valid at the next edge.
- Drain: down_valid[i] & down_ready[i] clears slot i unless slot i is loaded in the same cycle, in which case it holds the new beat.
- While down_valid[i] = 1 and down_ready[i] = 0, down_data for lane i must stay stable.
- The round-robin pointer advances only on an accepted beat in mode_rr = 1. It wraps from N-1 to 0. It never advances in explicit mode or on stall.
- A mode_rr change takes effect in the same cycle and does not reset rr_ptr.
- Illegal select (mode_rr = 0, up_sel ≥ N, up_valid = 1): beat accepted, no slot written, drop = 1 on the next cycle. This is only reachable when N is not a power of two.
- Up to one beat is accepted per cycle. Different lanes drain independently and concurrently.
- up_ready depends combinationally on down_ready[T], up_sel and mode_rr. No combinational path from up_valid to up_ready.

## Timing
- Reset (async assert, released synchronously to clk by the system): down_valid = 0, down_data = 0, rr_ptr = 0, drop = 0. up_ready then follows the free-slot rule, so it is 1 for any legal T after reset.
- Latency: a beat accepted at edge k appears on down_valid[T]/down_data at cycle k+1.
- Throughput: 1 beat/cycle sustained to any lane whose consumer holds down_ready = 1.
- Stalled lane T: up_ready = 0 until down_ready[T] = 1. The producer must hold up_valid, up_data and up_sel stable meanwhile; the block does not reorder beats.
- Reset asserted mid-transfer: all held beats are lost and outputs return to reset values immediately. No partial beat is ever presented.

## Test plan
- Reset and explicit route: WIDTH=8, N=4, mode_rr=0. Send 0xA1 with sel=2 → down_valid = 4'b0100, lane 2 data = 0xA1 one cycle later; other lanes stay 0. Assert rst mid-hold → down_valid = 0 immediately.
- Round-robin wrap: mode_rr=1, all down_ready=1. Send 6 beats 0x10..0x15 back-to-back → lanes 0,1,2,3,0,1 receive them; rr_ptr ends at 2; up_ready stays 1 every cycle.
- Backpressure and hold: lane 1 down_ready=0, send 0x55 then 0x66 to sel=1 → 0x55 is held stable, up_ready = 0 for the second beat. Raise down_ready[1] for 1 cycle → 0x55 consumed, 0x66 loaded the same edge, no bubble.
- Independent lanes: lane 0 stalled holding 0x01; beats to sel=3 continue at full rate → lane 3 delivers each beat; lane 0 is unchanged.
- Illegal select: N=3, mode_rr=0, sel=3, data 0x77 → up_ready = 1, drop pulses 1 cycle, no down_valid rises. N=3 round-robin over 4 beats → lanes 0,1,2,0.
- Stall does not advance pointer: mode_rr=1, lane 0 down_ready=0 with slot full → rr_ptr stays 0 and up_ready = 0 until lane 0 drains.
